// File: rtl/alu_trace_recorder.sv
// rtl/alu_trace_recorder.sv - trace buffer recording ALUSystem datapath results (optional macro: TRACE_WRAP_EN)
module alu_trace_recorder #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic             sample_en_i,
  input  logic [3:0]       trig_mask_i,
  input  logic [3:0]       trig_value_i,
  input  logic [7:0]       alu_out_i,
  input  logic [3:0]       alu_zcno_i,
  input  logic [7:0]       mem_address_i,
  input  logic [7:0]       mem_out_i,
  input  logic [15:0]      ir_out_i,
  input  logic             rd_req_i,
  output logic [43:0]      rd_data_o,
  output logic             rd_valid_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W - 1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [43:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             wr_en;
  logic [43:0]      wr_rec;
  logic [43:0]      mem_q [DEPTH];

  logic trig_hit;
  logic is_full;
  logic is_empty;

  assign wr_rec   = {ir_out_i, mem_out_i, mem_address_i, alu_zcno_i, alu_out_i};
  assign trig_hit = sample_en_i && ((alu_zcno_i & trig_mask_i) == (trig_value_i & trig_mask_i));
  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);

  // State, pointers and read port registers; cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; contents need no reset since Count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_rec;
  end

  // Next-state: session control, capture writes and pop-style reads.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm_i) begin
          // Arm wins over a same-cycle read; the session starts clean.
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = ARMED;
        end else begin
          if (rd_req_i && !is_empty) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            count_d    = count_q - CNT_ONE;
          end
`ifndef TRACE_WRAP_EN
          // Samples arriving after an automatic stop are lost.
          if (state_q == DONE && sample_en_i) overflow_d = 1'b1;
`endif
        end
      end
      ARMED: begin
        if (stop_i) begin
          state_d = DONE;
        end else if (trig_hit) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop_i) begin
          state_d = DONE;
        end else if (sample_en_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
`ifdef TRACE_WRAP_EN
          if (is_full) begin
            // Circular mode: drop the oldest record to keep the newest DEPTH.
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
`else
          count_d = count_q + CNT_ONE;
          if (count_q == FULL_CNT - CNT_ONE) state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign empty_o    = is_empty;
  assign full_o     = is_full;
  assign overflow_o = overflow_q;
  assign state_o    = state_q;

endmodule
